// File: rtl/cpu_pkg.sv
// Shared types for the vector CPU core: register addresses, forward-select
// encoding and the performance-counter width.
package cpu_pkg;

    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // The younger producer (Memory) holds the newer value, so it wins.
    function automatic fwd_sel_e fwd_select(input logic match_m, input logic match_w);
        if (match_m)      return FWD_MEM;
        else if (match_w) return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with asynchronous active-low clear; sticks at all-ones.
module hazard_sat_counter
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding, stall/flush and event counters.
// HAZARD_FWD_EN selects Memory/Writeback forwarding; without it RAW hazards stall.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3E,
    input  logic             MemtoRegE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             FlushD,
    input  logic             RegWriteE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic data_stall_d;
    logic pc_wr_pending_f;
    logic unused_cfg;

`ifdef HAZARD_FWD_EN
    logic match_1e_m, match_1e_w, match_2e_m, match_2e_w;

    assign match_1e_m = RegWriteM & (RA1E == WA3M);
    assign match_1e_w = RegWriteW & (RA1E == WA3W);
    assign match_2e_m = RegWriteM & (RA2E == WA3M);
    assign match_2e_w = RegWriteW & (RA2E == WA3W);

    assign ForwardAE = fwd_select(match_1e_m, match_1e_w);
    assign ForwardBE = fwd_select(match_2e_m, match_2e_w);

    // Only a load cannot be forwarded in time: its data appears in Memory.
    assign data_stall_d = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign unused_cfg   = RegWriteE;
`else
    assign ForwardAE = FWD_RF;
    assign ForwardBE = FWD_RF;

    // Writeback needs no stall: the register file writes in the first half-cycle.
    assign data_stall_d = (RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E)))
                        | (RegWriteM & ((RA1D == WA3M) | (RA2D == WA3M)));
    assign unused_cfg   = ^{RA1E, RA2E, WA3W, RegWriteW, MemtoRegE};
`endif

    assign pc_wr_pending_f = PCSrcD | PCSrcE | PCSrcM;

    assign StallD = data_stall_d;
    assign StallF = data_stall_d | pc_wr_pending_f;
    assign FlushD = pc_wr_pending_f | PCSrcW | BranchTakenE;
    assign FlushE = data_stall_d | BranchTakenE;

    hazard_sat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallD),
        .count (StallCount)
    );

    hazard_sat_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushE),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven check of hazard_unit outputs plus counter sequences, via a scoreboard queue.
module tb_hazard_unit;
    import cpu_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [1:0] EM = FWD ? 2'b10 : 2'b00;
    localparam logic [1:0] EW = FWD ? 2'b01 : 2'b00;
    localparam logic       R  = FWD ? 1'b0 : 1'b1;

    logic clk, rst_n;
    logic [3:0] RA1E, RA2E, WA3M, WA3W, RA1D, RA2D, WA3E;
    logic RegWriteM, RegWriteW, MemtoRegE, RegWriteE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, FlushE, FlushD;
    logic [15:0] StallCount, FlushCount;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .RA1E(RA1E), .RA2E(RA2E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E), .MemtoRegE(MemtoRegE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .FlushD(FlushD),
        .RegWriteE(RegWriteE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] ra1e, ra2e, wa3m, wa3w, ra1d, ra2d, wa3e;
        logic       rwm, rww, mtre, rwe, bte;
        logic [3:0] pc;   // {D,E,M,W}
        logic [5:0] exp;  // {fa, fb, sf, sd, fd, fe}
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_sc, exp_fc;

    task automatic add(input string nm,
                       input logic [3:0] ra1e, ra2e, wa3m, wa3w, input logic rwm, rww,
                       input logic [3:0] ra1d, ra2d, wa3e, input logic mtre, rwe,
                       input logic [3:0] pc, input logic bte,
                       input logic [1:0] fa, fb, input logic sf, sd, fd, fe);
        vec_t v;
        v.name = nm;
        v.ra1e = ra1e; v.ra2e = ra2e; v.wa3m = wa3m; v.wa3w = wa3w;
        v.rwm = rwm; v.rww = rww;
        v.ra1d = ra1d; v.ra2d = ra2d; v.wa3e = wa3e; v.mtre = mtre; v.rwe = rwe;
        v.pc = pc; v.bte = bte;
        v.exp = {fa, fb, sf, sd, fd, fe};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        RA1E = v.ra1e; RA2E = v.ra2e; WA3M = v.wa3m; WA3W = v.wa3w;
        RegWriteM = v.rwm; RegWriteW = v.rww;
        RA1D = v.ra1d; RA2D = v.ra2d; WA3E = v.wa3e; MemtoRegE = v.mtre; RegWriteE = v.rwe;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = v.pc;
        BranchTakenE = v.bte;
    endtask

    task automatic expect_val(input string nm, input logic [31:0] e);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check(input logic [31:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic check_counts(input string nm);
        expect_val({nm, "_stall"}, {16'h0, exp_sc});
        check({16'h0, StallCount});
        expect_val({nm, "_flush"}, {16'h0, exp_fc});
        check({16'h0, FlushCount});
    endtask

    task automatic cyc(input int n, input bit sd, input bit fe);
        repeat (n) begin
            @(posedge clk);
            if (sd && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
            if (fe && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
        end
        #1;
    endtask

    vec_t idle_v, ldu_v, pce_v, br_v, ldbr_v;

    initial begin
        //   name            ra1e ra2e wa3m wa3w rwm rww ra1d ra2d wa3e mtre rwe pc       bte fa     fb     sf sd fd fe
        add("fwd_mem_r0",    0,   0,   0,   0,   1,  0,  5,   6,   7,   0,   0,  4'b0000, 0,  EM,    EM,    0, 0, 0, 0);
        add("fwd_wb_a",      1,   2,   0,   1,   1,  1,  5,   6,   7,   0,   0,  4'b0000, 0,  EW,    2'b00, 0, 0, 0, 0);
        add("fwd_mem_prio",  1,   1,   1,   1,   1,  1,  5,   6,   7,   0,   0,  4'b0000, 0,  EM,    EM,    0, 0, 0, 0);
        add("fwd_no_match",  1,   1,   0,   0,   1,  0,  5,   6,   7,   0,   0,  4'b0000, 0,  2'b00, 2'b00, 0, 0, 0, 0);
        add("fwd_rw_off",    3,   3,   3,   3,   0,  0,  5,   6,   7,   0,   0,  4'b0000, 0,  2'b00, 2'b00, 0, 0, 0, 0);
        add("fwd_wb_b",      4,   9,   9,   9,   0,  1,  5,   6,   7,   0,   0,  4'b0000, 0,  2'b00, EW,    0, 0, 0, 0);
        add("ldu_ra2",       8,   8,   10,  11,  0,  0,  5,   3,   3,   1,   1,  4'b0000, 0,  2'b00, 2'b00, 1, 1, 0, 1);
        add("ld_no_use",     8,   8,   10,  11,  0,  0,  5,   6,   3,   1,   1,  4'b0000, 0,  2'b00, 2'b00, 0, 0, 0, 0);
        add("ldu_r0",        8,   8,   10,  11,  0,  0,  0,   6,   0,   1,   1,  4'b0000, 0,  2'b00, 2'b00, 1, 1, 0, 1);
        add("raw_e",         8,   8,   10,  11,  0,  0,  5,   6,   6,   0,   1,  4'b0000, 0,  2'b00, 2'b00, R, R, 0, R);
        add("raw_m",         8,   8,   5,   11,  1,  0,  5,   6,   7,   0,   0,  4'b0000, 0,  2'b00, 2'b00, R, R, 0, R);
        add("pcsrc_e",       8,   8,   10,  11,  0,  0,  5,   6,   7,   0,   0,  4'b0100, 0,  2'b00, 2'b00, 1, 0, 1, 0);
        add("pcsrc_d",       8,   8,   10,  11,  0,  0,  5,   6,   7,   0,   0,  4'b1000, 0,  2'b00, 2'b00, 1, 0, 1, 0);
        add("pcsrc_m",       8,   8,   10,  11,  0,  0,  5,   6,   7,   0,   0,  4'b0010, 0,  2'b00, 2'b00, 1, 0, 1, 0);
        add("pcsrc_w",       8,   8,   10,  11,  0,  0,  5,   6,   7,   0,   0,  4'b0001, 0,  2'b00, 2'b00, 0, 0, 1, 0);
        add("branch",        8,   8,   10,  11,  0,  0,  5,   6,   7,   0,   0,  4'b0000, 1,  2'b00, 2'b00, 0, 0, 1, 1);
        add("ldu_branch",    8,   8,   10,  11,  0,  0,  5,   3,   3,   1,   1,  4'b0000, 1,  2'b00, 2'b00, 1, 1, 1, 1);
        add("ldu_pcsrc_e",   8,   8,   10,  11,  0,  0,  5,   3,   3,   1,   1,  4'b0100, 0,  2'b00, 2'b00, 1, 1, 1, 1);

        idle_v = tbl[4];
        ldu_v  = tbl[6];
        pce_v  = tbl[11];
        br_v   = tbl[15];
        ldbr_v = tbl[16];

        rst_n = 1'b0;
        drive(idle_v);
        exp_sc = 16'h0;
        exp_fc = 16'h0;
        #1;
        check_counts("reset_state");

        // Hazard outputs are combinational and ignore reset; counters stay at 0.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            expect_val(tbl[i].name, {26'h0, tbl[i].exp});
            #2;
            check({26'h0, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE});
        end
        @(posedge clk);
        #1;
        check_counts("held_in_reset");

        @(negedge clk);
        drive(idle_v);
        rst_n = 1'b1;
        cyc(2, 0, 0);
        check_counts("idle");

        @(negedge clk); drive(ldu_v);  cyc(3, 1, 1); check_counts("ldu_3cyc");
        @(negedge clk); drive(pce_v);  cyc(2, 0, 0); check_counts("pcsrc_e_2cyc");
        @(negedge clk); drive(br_v);   cyc(2, 0, 1); check_counts("branch_2cyc");
        @(negedge clk); drive(ldbr_v); cyc(1, 1, 1); check_counts("ldu_branch");

        @(negedge clk); drive(ldu_v);  cyc(70000, 1, 1); check_counts("saturate");
        cyc(3, 1, 1);
        check_counts("no_wrap");

        // Mid-cycle reset pulse clears counters immediately.
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_sc = 16'h0;
        exp_fc = 16'h0;
        #1;
        check_counts("async_clear");
        @(posedge clk);
        #1;
        check_counts("clear_held");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 1);
        check_counts("count_after_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
